// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage bundle: EX/MEM register outputs in, stall/branch
// feedback and the MEM/WB register contents out.
interface mem_stage_if #(
  parameter int DATA_W = 128,
  parameter int REG_W  = 7,
  parameter int PC_W   = 11
);
  logic              mem_to_reg_in;
  logic              reg_write_in;
  logic              branch_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic [PC_W-1:0]   jump_pc_in;
  logic              zero_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] store_data_in;
  logic [REG_W-1:0]  reg_rt_in;

  logic              stall;
  logic              pc_src;
  logic [PC_W-1:0]   branch_target;
  logic              wb_mem_to_reg;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_alu_result;
  logic [REG_W-1:0]  wb_reg_rt;

  modport slave (
    input  mem_to_reg_in, reg_write_in, branch_in, mem_read_in, mem_write_in,
           jump_pc_in, zero_in, alu_result_in, store_data_in, reg_rt_in,
    output stall, pc_src, branch_target,
           wb_mem_to_reg, wb_reg_write, wb_mem_data, wb_alu_result, wb_reg_rt
  );

  modport master (
    output mem_to_reg_in, reg_write_in, branch_in, mem_read_in, mem_write_in,
           jump_pc_in, zero_in, alu_result_in, store_data_in, reg_rt_in,
    input  stall, pc_src, branch_target,
           wb_mem_to_reg, wb_reg_write, wb_mem_data, wb_alu_result, wb_reg_rt
  );
endinterface

// File: rtl/mem_stage.sv
// SPU MEM stage: fixed-latency quadword local store access, branch resolve,
// and the MEM/WB pipeline register.
module mem_stage #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 2,
  parameter int REG_W   = 7,
  parameter int PC_W    = 11
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              stall_c, done;
  logic              memop;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign memop = bus.mem_read_in | bus.mem_write_in;
  // Quadword index: byte offset bits and bits above the store depth are dropped.
  assign idx   = bus.alu_result_in[ADDR_W+3:4];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.alu_result_in[3:0], bus.alu_result_in[DATA_W-1:ADDR_W+4]};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_c  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (memop) begin
          if (MEM_LAT == 1) begin
            done = 1'b1;
          end else begin
            stall_c  = 1'b1;
            state_nx = ACCESS;
            cnt_nx   = 4'(MEM_LAT - 1);
          end
        end
      end
      ACCESS: begin
        if (cnt > 4'd1) begin
          stall_c = 1'b1;
          cnt_nx  = cnt - 4'd1;
        end else begin
          done     = 1'b1;
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Reset gates the commit so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!reset && done && bus.mem_write_in)
      mem[idx] <= bus.store_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset || stall_c) begin
      bus.wb_mem_to_reg <= 1'b0;
      bus.wb_reg_write  <= 1'b0;
      bus.wb_mem_data   <= '0;
      bus.wb_alu_result <= '0;
      bus.wb_reg_rt     <= '0;
    end else begin
      bus.wb_mem_to_reg <= bus.mem_to_reg_in;
      bus.wb_reg_write  <= bus.reg_write_in;
      bus.wb_mem_data   <= (done && bus.mem_read_in) ? mem[idx] : '0;
      bus.wb_alu_result <= bus.alu_result_in;
      bus.wb_reg_rt     <= bus.reg_rt_in;
    end
  end

  assign bus.stall         = stall_c;
  assign bus.pc_src        = bus.branch_in & bus.zero_in & ~stall_c;
  assign bus.branch_target = bus.jump_pc_in;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (MEM_LAT 2 and 4) driven one at a time
// against a transaction-level model of stage occupancy and local store contents.
module tb_mem_stage;
  localparam int DW = 128, AW = 10, RW = 7, PW = 11;

  typedef struct packed {
    logic m2r, rw, br, mr, mw;
    logic [PW-1:0] jpc;
    logic zero;
    logic [DW-1:0] alu, sd;
    logic [RW-1:0] rt;
  } req_t;

  typedef struct packed {
    logic m2r, rw;
    logic [DW-1:0] mdata, alu;
    logic [RW-1:0] rt;
  } wb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst;
  req_t [1:0]          req;
  wb_t  [1:0]          wb;
  logic [1:0]          stall, pc_src;
  logic [1:0][PW-1:0]  tgt;

  for (genvar g = 0; g < 2; g++) begin : lane
    mem_stage_if #(.DATA_W(DW), .REG_W(RW), .PC_W(PW)) bus();
    mem_stage #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(g == 0 ? 2 : 4), .REG_W(RW), .PC_W(PW))
      dut (.clk(clk), .reset(rst[g]), .bus(bus));
    assign bus.mem_to_reg_in = req[g].m2r;
    assign bus.reg_write_in  = req[g].rw;
    assign bus.branch_in     = req[g].br;
    assign bus.mem_read_in   = req[g].mr;
    assign bus.mem_write_in  = req[g].mw;
    assign bus.jump_pc_in    = req[g].jpc;
    assign bus.zero_in       = req[g].zero;
    assign bus.alu_result_in = req[g].alu;
    assign bus.store_data_in = req[g].sd;
    assign bus.reg_rt_in     = req[g].rt;
    assign stall[g]  = bus.stall;
    assign pc_src[g] = bus.pc_src;
    assign tgt[g]    = bus.branch_target;
    assign wb[g]     = {bus.wb_mem_to_reg, bus.wb_reg_write, bus.wb_mem_data,
                        bus.wb_alu_result, bus.wb_reg_rt};
  end

  logic [DW-1:0] ref_mem [2][1024];
  wb_t           exp_wb [2];
  int            n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : 4;
  endfunction

  function automatic req_t op(input logic m2r, rw, br, mr, mw, input logic [PW-1:0] jpc,
                              input logic zero, input logic [DW-1:0] alu, sd, input logic [RW-1:0] rt);
    req_t r;
    r = '{m2r:m2r, rw:rw, br:br, mr:mr, mw:mw, jpc:jpc, zero:zero, alu:alu, sd:sd, rt:rt};
    return r;
  endfunction

  // Present one instruction, held for its whole stay in the stage, and check every cycle.
  task automatic issue(input int g, input req_t r);
    int  n, idx;
    wb_t nx;
    req[g] = r;
    n = (r.mr | r.mw) ? lat_of(g) : 1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("stall", 300'(stall[g]), 300'(k < n - 1));
      chk("pc_src", 300'(pc_src[g]), 300'(r.br & r.zero & (k == n - 1)));
      chk("target", 300'(tgt[g]), 300'(r.jpc));
      if (k == 0) chk("wb", 300'(wb[g]), 300'(exp_wb[g]));
      else        chk("wb_bubble", 300'(wb[g]), 300'(0));
      @(posedge clk); #1;
    end
    idx = int'((r.alu >> 4) % 128'd1024);
    nx.m2r   = r.m2r;
    nx.rw    = r.rw;
    nx.alu   = r.alu;
    nx.rt    = r.rt;
    nx.mdata = r.mr ? ref_mem[g][idx] : '0;
    if (r.mw) ref_mem[g][idx] = r.sd;
    exp_wb[g] = nx;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Random byte address whose quadword index lands in 0..7, upper bits arbitrary.
  function automatic logic [DW-1:0] rnd_addr();
    logic [DW-1:0] a;
    a = rnd128();
    a[13:7] = '0;
    return a;
  endfunction

  localparam logic [DW-1:0] PAT = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  initial begin
    req_t bub;
    req_t r;
    int   kind;
    bub = '0;
    req = '0;
    rst = 2'b11;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_wb", 300'(wb[g]), 300'(0));
      chk("rst_stall", 300'(stall[g]), 300'(0));
    end
    @(posedge clk); #1;
    rst = 2'b00;
    exp_wb[0] = '0;
    exp_wb[1] = '0;

    for (int g = 0; g < 2; g++) begin
      issue(g, bub);
      issue(g, op(0, 1, 0, 0, 0, 11'h0, 0, 128'h1234, 128'h0, 7'd5));
      for (int i = 0; i < 8; i++)
        issue(g, op(0, 0, 0, 0, 1, 11'h0, 0, 128'(i) << 4, rnd128(), 7'd0));

      issue(g, op(0, 0, 0, 0, 1, 11'h0, 0, 128'h40, PAT, 7'd0));
      issue(g, op(1, 1, 0, 1, 0, 11'h0, 0, 128'h4F, 128'h0, 7'd9));
      issue(g, op(0, 0, 1, 0, 0, 11'h155, 1, 128'h0, 128'h0, 7'd0));
      issue(g, op(0, 0, 1, 0, 0, 11'h155, 0, 128'h0, 128'h0, 7'd0));
      issue(g, op(0, 0, 0, 0, 1, 11'h0, 0, (128'd1 << (AW + 4)) + 128'h10, ~PAT, 7'd0));
      issue(g, op(1, 1, 0, 1, 0, 11'h0, 0, 128'h10, 128'h0, 7'd3));

      // Abort a store by resetting while it is in flight.
      req[g] = op(0, 0, 0, 0, 1, 11'h0, 0, 128'h20, rnd128(), 7'd0);
      @(negedge clk);
      chk("abort_stall", 300'(stall[g]), 300'(1));
      chk("abort_wb", 300'(wb[g]), 300'(exp_wb[g]));
      @(posedge clk); #1;
      rst[g] = 1'b1;
      req[g] = bub;
      @(posedge clk); #1;
      rst[g] = 1'b0;
      exp_wb[g] = '0;
      issue(g, bub);
      issue(g, op(1, 1, 0, 1, 0, 11'h0, 0, 128'h20, 128'h0, 7'd4));

      for (int i = 0; i < 120; i++) begin
        kind = int'($urandom_range(0, 4));
        r = op(1'($urandom), 1'($urandom), 1'($urandom), kind == 1 || kind == 3,
               kind == 2 || kind == 3, 11'($urandom), 1'($urandom), rnd_addr(), rnd128(),
               7'($urandom));
        if (kind == 4) r = bub;
        issue(g, r);
      end
      issue(g, bub);
      issue(g, bub);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
